// File: rtl/funct_generator_adder_arb.sv
// rtl/funct_generator_adder_arb.sv - round-robin arbiter sharing one funct_generator_adder
// Grants one requester at a time, runs its operands through the adder, returns the sum on a valid/ready port.
module funct_generator_adder_arb #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH_IN  = 5,
  parameter int DATA_WIDTH_OUT = 6,
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             clrh,
  input  logic [NUM_REQ-1:0]               req_i,
  input  logic [NUM_REQ*DATA_WIDTH_IN-1:0] data_a_i,
  input  logic [NUM_REQ*DATA_WIDTH_IN-1:0] data_b_i,
  input  logic [NUM_REQ*DATA_WIDTH_IN-1:0] data_c_i,
  output logic [NUM_REQ-1:0]               gnt_o,
  output logic                             add_clrh_o,
  output logic                             add_enh_o,
  output logic [DATA_WIDTH_IN-1:0]         add_a_o,
  output logic [DATA_WIDTH_IN-1:0]         add_b_o,
  output logic [DATA_WIDTH_IN-1:0]         add_c_o,
  input  logic [DATA_WIDTH_OUT-1:0]        add_sum_i,
  output logic                             res_valid_o,
  input  logic                             res_ready_i,
  output logic [DATA_WIDTH_OUT-1:0]        res_data_o,
  output logic [ID_W-1:0]                  res_id_o
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESULT} state_t;

  state_t                    r_state, w_state_nxt;
  logic [ID_W-1:0]           r_last, r_id, w_win, w_cand;
  logic                      w_any;
  logic [DATA_WIDTH_IN-1:0]  r_a, r_b, r_c;
  logic [NUM_REQ-1:0]        r_gnt;
  logic                      r_res_valid;
  logic [DATA_WIDTH_OUT-1:0] r_res_data;
  logic [ID_W-1:0]           r_res_id;

  // Scan starts one past the last winner, so a held request waits at most NUM_REQ rounds.
  always_comb begin
    w_win  = r_last;
    w_any  = 1'b0;
    w_cand = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = ID_W'((int'(r_last) + i) % NUM_REQ);
      if (!w_any && req_i[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clrh) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    add_enh_o   = 1'b0;
    add_clrh_o  = 1'b1;
    case (r_state)
      S_IDLE:   if (w_any) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        add_enh_o   = 1'b1;
        add_clrh_o  = 1'b0;
        w_state_nxt = S_RESULT;
      end
      S_RESULT: if (res_ready_i) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clrh) begin
      r_last      <= ID_W'(NUM_REQ - 1);
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_gnt       <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_last <= w_win;
          r_id   <= w_win;
          r_gnt  <= NUM_REQ'(1) << w_win;
          r_a    <= data_a_i[int'(w_win)*DATA_WIDTH_IN +: DATA_WIDTH_IN];
          r_b    <= data_b_i[int'(w_win)*DATA_WIDTH_IN +: DATA_WIDTH_IN];
          r_c    <= data_c_i[int'(w_win)*DATA_WIDTH_IN +: DATA_WIDTH_IN];
        end
        S_ISSUE: begin
          r_gnt       <= '0;
          r_res_valid <= 1'b1;
          r_res_data  <= add_sum_i;
          r_res_id    <= r_id;
        end
        S_RESULT: if (res_ready_i) r_res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign gnt_o       = r_gnt;
  assign add_a_o     = r_a;
  assign add_b_o     = r_b;
  assign add_c_o     = r_c;
  assign res_valid_o = r_res_valid;
  assign res_data_o  = r_res_data;
  assign res_id_o    = r_res_id;
endmodule

// File: doc/funct_generator_adder_arb.md
# funct_generator_adder_arb

Round-robin arbiter and sequencer that shares one `funct_generator_adder` instance among `NUM_REQ` requesters in the function generator datapath. It accepts one three-operand request at a time and drives the adder's `clrh`/`enh` and operand inputs. It captures the sum into an output register and presents it with the winning requester's index on a valid/ready result port. Sits between the waveform channel logic and the adder; the result port feeds the output FIFO.

## Interface
- `NUM_REQ`, 4: number of requesters; ≥2.
- `DATA_WIDTH_IN`, 5: operand width; matches the adder.
- `DATA_WIDTH_OUT`, 6: sum width; matches the adder.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester index (derived, do not override).
- `clk`  in  1  single clock; all state updates on rising edge.
- `clrh`  in  1  reset, synchronous, active-high.
- `req_i`  in  NUM_REQ  per-requester request level; held until granted.
- `data_a_i`, `data_b_i`, `data_c_i`  in  NUM_REQ*DATA_WIDTH_IN each  flattened operands; requester k occupies bits [k*DATA_WIDTH_IN +: DATA_WIDTH_IN]; stable while `req_i[k]`=1.
- `gnt_o`  out  NUM_REQ  one-hot grant, registered, one-cycle pulse.
- `add_clrh_o`  out  1  to adder `clrh`.
- `add_enh_o`  out  1  to adder `enh`.
- `add_a_o`, `add_b_o`, `add_c_o`  out  DATA_WIDTH_IN each  to adder operand inputs.
- `add_sum_i`  in  DATA_WIDTH_OUT  from adder `data_o`.
- `res_valid_o`  out  1  result valid.
- `res_ready_i`  in  1  downstream ready.
- `res_data_o`  out  DATA_WIDTH_OUT  registered sum.
- `res_id_o`  out  ID_W  index of the requester that owns `res_data_o`.

## Operation
- FSM states: IDLE, ISSUE, RESULT.
- IDLE:
  - If `req_i`≠0, select the winner by round-robin: search `last+1, last+2, …` mod NUM_REQ and take the first set bit.
  - At the edge, latch the winner's three operands and index, set `gnt_o` one-hot for the winner, set `last`=winner, and go to ISSUE.
  - If `req_i`=0, stay in IDLE.
- ISSUE:
  - `add_enh_o`=1, `add_clrh_o`=0, operands are driven from the latches.
  - At the edge, capture `add_sum_i` into `res_data_o` and the latched index into `res_id_o`, set `res_valid_o`=1, clear `gnt_o`, and go to RESULT.
- RESULT:
  - Hold `res_data_o`, `res_id_o` and `res_valid_o`.
  - When `res_valid_o`&&`res_ready_i` at an edge, clear `res_valid_o` and go to IDLE.
  - No arbitration occurs while in RESULT.
- `add_clrh_o`=1 and `add_enh_o`=0 in IDLE and RESULT, so the adder output reads 0 outside ISSUE.
- Operand latches drive `add_*_o` at all times; values are don't-care outside ISSUE.
- Arithmetic: `res_data_o` = (a+b+c) mod 2^DATA_WIDTH_OUT, passed through from the adder without alteration. With the defaults, sums above 63 wrap.
- Requesters sample `gnt_o` and must deassert `req_i` no later than the cycle after the grant pulse. Guaranteed slack: the block is not back in IDLE until at least 2 cycles after the grant.
- Unused requesters tie `req_i[k]`=0; they are never granted.

## Timing
- Reset values:
  - state=IDLE; `gnt_o`=0; `res_valid_o`=0; `res_data_o`=0; `res_id_o`=0.
  - Operand latches = 0; `last`=NUM_REQ-1, so requester 0 has first priority.
  - `add_clrh_o`=1; `add_enh_o`=0.
- `clrh` overrides everything in any state. An in-flight grant or result is discarded with no `gnt_o` pulse and no `res_valid_o`; pending requests re-arbitrate from requester 0 after reset.
- Latency for a request seen in IDLE at cycle 0:
  - `gnt_o` high in cycle 1, with ISSUE and `add_enh_o`=1.
  - `res_valid_o` high from cycle 2.
- Throughput: one result per 3 cycles with `res_ready_i` held at 1; longer under backpressure.
- `res_ready_i` is ignored while `res_valid_o`=0. `res_valid_o` never drops without a handshake except on reset.
- Simultaneous requests: exactly one grant per arbitration; the others wait. Starvation-free: any held request is granted within NUM_REQ arbitrations.

## Test plan
- Single request: `req_i`=0001, operands 3,4,5 at cycle 0 -> `gnt_o`=0001 in cycle 1; `res_valid_o`=1, `res_data_o`=12, `res_id_o`=0 in cycle 2; one cycle later, with `res_ready_i`=1, back in IDLE.
- Rotation: `req_i`=1111 held, each requester dropping after its grant, `res_ready_i`=1 -> grant order 0,1,2,3; `res_id_o` sequence 0,1,2,3 at 3-cycle spacing.
- Fairness after reset: requester 2 granted first, then `req_i`=0101 -> next grant is requester 0 (search starts at 3), then requester 2.
- Wrap: operands 31,31,31 -> `res_data_o`=29 (93 mod 64).
- Backpressure: `res_ready_i`=0 for 5 cycles while `req_i`=0010 -> `res_valid_o` and `res_data_o` stable, no new `gnt_o`; on release, handshake, then grant requester 1 two cycles later.
- Reset mid-operation: assert `clrh` in the ISSUE cycle -> next cycle all outputs at reset values, no `res_valid_o`; the held request is re-granted 2 cycles after `clrh` drops.
